piso_tx: RTL and testbench

PISO_TX -- requirements
Module: piso_tx

---
 rtl/piso_tx.sv | 93 +++++++++
 tb/tb_piso_tx.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/piso_tx.sv
// Parallel-in serial-out transmitter with a one-word holding register.
// Words queued in the holding register follow the current frame with no gap.
module piso_tx #(
    parameter int unsigned WIDTH     = 8,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data_in,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             data_out,
    output logic             load,
    output logic             busy,
    output logic             done
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic S_IDLE  = 1'b0;
    localparam logic S_SHIFT = 1'b1;

    logic             r_state;
    logic [WIDTH-1:0] r_hold;
    logic             r_hold_full;
    logic [WIDTH-1:0] r_shift;
    logic [CW-1:0]    r_cnt;

    logic             w_accept;
    logic             w_last;
    logic             w_xfer;
    logic [WIDTH-1:0] w_shift_next;

    assign in_ready = rst & ~r_hold_full;
    assign w_accept = in_valid & in_ready;
    assign w_last   = (r_state == S_SHIFT) && (r_cnt == CW'(WIDTH - 1));
    // Holding register drains when idle or when the current frame ends.
    assign w_xfer   = r_hold_full && ((r_state == S_IDLE) || w_last);

    assign w_shift_next = MSB_FIRST ? {r_shift[WIDTH-2:0], 1'b0}
                                    : {1'b0, r_shift[WIDTH-1:1]};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_hold      <= '0;
            r_hold_full <= 1'b0;
        end else if (w_accept) begin
            r_hold      <= data_in;
            r_hold_full <= 1'b1;
        end else if (w_xfer) begin
            r_hold_full <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_shift <= '0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (r_hold_full) begin
                        r_shift <= r_hold;
                        r_cnt   <= '0;
                        r_state <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    if (w_last) begin
                        r_cnt <= '0;
                        if (r_hold_full) begin
                            r_shift <= r_hold;
                        end else begin
                            r_shift <= '0;
                            r_state <= S_IDLE;
                        end
                    end else begin
                        r_shift <= w_shift_next;
                        r_cnt   <= r_cnt + CW'(1);
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign load     = (r_state == S_SHIFT);
    assign data_out = load & (MSB_FIRST ? r_shift[WIDTH-1] : r_shift[0]);
    assign done     = w_last;
    assign busy     = load | r_hold_full;

endmodule

// File: tb/tb_piso_tx.sv
// Scoreboard bench for piso_tx: an MSB-first and an LSB-first instance.
module tb_piso_tx;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic       in_valid = 1'b0;
    logic       in_ready, data_out, load, busy, done;

    logic [7:0] data_in_l = 8'h00;
    logic       in_valid_l = 1'b0;
    logic       in_ready_l, data_out_l, load_l, busy_l, done_l;

    int passed = 0;
    int total  = 0;

    logic [1:0] exp_q[$];
    logic [1:0] exp_ql[$];
    int load_cnt = 0, done_cnt = 0, run = 0, max_run = 0;
    int load_cnt_l = 0;

    always #5 clk = ~clk;

    piso_tx #(.WIDTH(8), .MSB_FIRST(1'b1)) dut (
        .clk(clk), .rst(rst), .data_in(data_in), .in_valid(in_valid),
        .in_ready(in_ready), .data_out(data_out), .load(load), .busy(busy), .done(done)
    );

    piso_tx #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_l (
        .clk(clk), .rst(rst), .data_in(data_in_l), .in_valid(in_valid_l),
        .in_ready(in_ready_l), .data_out(data_out_l), .load(load_l), .busy(busy_l),
        .done(done_l)
    );

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d, required %0d", name, act, exp);
    endtask

    // Each serial bit is paired with its expected done flag as {done, bit}.
    always @(negedge clk) begin
        if (load) begin
            load_cnt++;
            if (done) done_cnt++;
            run++;
            if (run > max_run) max_run = run;
            if (exp_q.size() == 0) begin
                total++;
                $display("FAIL msb_unexpected_bit: got load=1 data_out=%0b, required load=0",
                         data_out);
            end else begin
                check("msb_bit_done", int'({done, data_out}), int'(exp_q.pop_front()));
            end
        end else begin
            run = 0;
        end
    end

    always @(negedge clk) begin
        if (load_l) begin
            load_cnt_l++;
            if (exp_ql.size() == 0) begin
                total++;
                $display("FAIL lsb_unexpected_bit: got load=1 data_out=%0b, required load=0",
                         data_out_l);
            end else begin
                check("lsb_bit_done", int'({done_l, data_out_l}), int'(exp_ql.pop_front()));
            end
        end
    end

    task automatic push_word(input logic [7:0] w, output int waits);
        int n = 0;
        @(negedge clk);
        data_in  = w;
        in_valid = 1'b1;
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        waits = n;
        if (!in_ready) begin
            total++;
            $display("FAIL accept_timeout: got in_ready=0, required 1 within 200 cycles");
        end else begin
            @(posedge clk);
            for (int i = 0; i < 8; i++) exp_q.push_back({(i == 7), w[7-i]});
        end
        #1 in_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while ((busy || exp_q.size() != 0) && n < 200) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        check({name, "_busy"}, int'(busy), 0);
        check({name, "_load"}, int'(load), 0);
    endtask

    initial begin
        int w, l0, d0;
        // Reset held: outputs stay low and nothing is accepted.
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            data_in  = 8'hFF;
            in_valid = (i % 2 == 0);
            #1;
            check("rst_outputs", int'({load, data_out, done, busy, in_ready}), 0);
        end
        @(negedge clk);
        in_valid = 1'b0;
        rst = 1'b1;
        #1 check("rst_release_in_ready", int'(in_ready), 1);
        repeat (3) @(negedge clk);
        check("rst_no_accept", load_cnt + int'(busy), 0);

        // Single word F0.
        l0 = load_cnt; d0 = done_cnt; max_run = 0;
        push_word(8'hF0, w);
        wait_idle("f0");
        check("f0_load_cycles", load_cnt - l0, 8);
        check("f0_done_count", done_cnt - d0, 1);
        check("f0_run", max_run, 8);

        // Back-to-back AA, FF, then 3C under backpressure.
        l0 = load_cnt; d0 = done_cnt; max_run = 0;
        push_word(8'hAA, w);
        push_word(8'hFF, w);
        check("ff_wait_cycles", w, 1);
        push_word(8'h3C, w);
        check("3c_backpressure_cycles", w, 7);
        wait_idle("b2b");
        check("b2b_load_cycles", load_cnt - l0, 24);
        check("b2b_done_count", done_cnt - d0, 3);
        check("b2b_gapless_run", max_run, 24);

        // Mid-frame reset after 3 bits of C5 with 11 held.
        l0 = load_cnt;
        push_word(8'hC5, w);
        push_word(8'h11, w);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        exp_q.delete();
        #1;
        check("midrst_bits_sent", load_cnt - l0, 3);
        check("midrst_outputs", int'({load, data_out, done, busy, in_ready}), 0);
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("midrst_no_resume", int'(load | busy), 0);
        l0 = load_cnt; max_run = 0;
        push_word(8'h81, w);
        wait_idle("after_rst");
        check("after_rst_load_cycles", load_cnt - l0, 8);
        check("after_rst_run", max_run, 8);

        // LSB-first instance sends 01.
        @(negedge clk);
        check("lsb_in_ready", int'(in_ready_l), 1);
        data_in_l  = 8'h01;
        in_valid_l = 1'b1;
        @(posedge clk);
        for (int i = 0; i < 8; i++) exp_ql.push_back({(i == 7), data_in_l[i]});
        #1 in_valid_l = 1'b0;
        for (int n = 0; n < 200 && (busy_l || exp_ql.size() != 0); n++) @(negedge clk);
        @(negedge clk);
        check("lsb_load_cycles", load_cnt_l, 8);
        check("lsb_idle", int'(busy_l | load_l), 0);

        check("msb_queue_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
